// File: rtl/idex_stage_pkg.sv
// rtl/idex_stage_pkg.sv - shared opcodes, ID/EX field layout and FSM encoding for idex_stage
package idex_stage_pkg;

    localparam int DATA_W = 32;
    localparam int IFID_W = 44;
    localparam int IDEX_W = 160;

    // MIPS primary opcodes used by the extender and the load-use detector
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    // ID/EX register field offsets and widths
    localparam int FIELD_W   = 32;
    localparam int INSTR_LSB = 0;
    localparam int OPA_LSB   = 32;
    localparam int OPB_LSB   = 64;
    localparam int IMM_LSB   = 96;
    localparam int PC_LSB    = 128;
    localparam int PC_W      = 12;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [DATA_W-1:0] NOP_WORD = '0;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } idex_state_e;

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    endfunction

endpackage

// File: rtl/idex_stage_if.sv
// rtl/idex_stage_if.sv - ID/EX stage bus: IF/ID input, operands, forwarding, stall/flush and ID/EX output
// Optional macro IDEX_BUBBLE_CNT_EN adds bubble_cnt[15:0] (load-use bubble count, saturating).
// master: drives ifid_reg, busA, busB, ex_result, BusAchange, BusBchange, stall, flush
// slave : drives idex_reg, idex_valid, load_stall (and bubble_cnt when enabled)
interface idex_stage_if;
    import idex_stage_pkg::*;

    logic [IFID_W-1:0] ifid_reg;
    logic [DATA_W-1:0] busA;
    logic [DATA_W-1:0] busB;
    logic [DATA_W-1:0] ex_result;
    logic              BusAchange;
    logic              BusBchange;
    logic              stall;
    logic              flush;
    logic [IDEX_W-1:0] idex_reg;
    logic              idex_valid;
    logic              load_stall;
`ifdef IDEX_BUBBLE_CNT_EN
    logic [15:0]       bubble_cnt;

    modport master (
        output ifid_reg, busA, busB, ex_result, BusAchange, BusBchange, stall, flush,
        input  idex_reg, idex_valid, load_stall, bubble_cnt
    );
    modport slave (
        input  ifid_reg, busA, busB, ex_result, BusAchange, BusBchange, stall, flush,
        output idex_reg, idex_valid, load_stall, bubble_cnt
    );
`else
    modport master (
        output ifid_reg, busA, busB, ex_result, BusAchange, BusBchange, stall, flush,
        input  idex_reg, idex_valid, load_stall
    );
    modport slave (
        input  ifid_reg, busA, busB, ex_result, BusAchange, BusBchange, stall, flush,
        output idex_reg, idex_valid, load_stall
    );
`endif

endinterface

// File: rtl/idex_stage_imm_ext.sv
// rtl/idex_stage_imm_ext.sv - 16-to-32 immediate extender, zero-extend for logical immediates
// Ports: op_i (opcode), imm_i (instr[15:0]), imm_o (extended immediate)
module imm_ext
    import idex_stage_pkg::*;
(
    input  logic [5:0]        op_i,
    input  logic [15:0]       imm_i,
    output logic [DATA_W-1:0] imm_o
);

    logic zero_ext;

    assign zero_ext = (op_i == OP_ANDI) || (op_i == OP_ORI) || (op_i == OP_XORI);
    assign imm_o    = zero_ext ? {16'h0000, imm_i} : {{16{imm_i[15]}}, imm_i};

endmodule

// File: rtl/idex_stage.sv
// rtl/idex_stage.sv - ID/EX pipeline register with forwarding muxes, load-use bubble, stall and flush
// Ports: clk, rst_n (async active-low), bus (idex_stage_if.slave).
// Optional macro IDEX_BUBBLE_CNT_EN enables the saturating bubble_cnt output.
module idex_stage
    import idex_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    idex_stage_if.slave  bus
);

    logic [IDEX_W-1:0] idex_reg_q, idex_reg_d;
    logic              idex_valid_q, idex_valid_d;
    idex_state_e       state_q, state_d;

    logic [DATA_W-1:0] instr;
    logic [PC_W-1:0]   pc_lo;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] imm;
    logic [IDEX_W-1:0] capture;

    logic [5:0] ex_op;
    logic [4:0] ex_rt;
    logic [5:0] id_op;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       hazard;
    logic       bubble_req;

    assign instr = bus.ifid_reg[31:0];
    assign pc_lo = bus.ifid_reg[43:32];

    assign opa = bus.BusAchange ? bus.ex_result : bus.busA;
    assign opb = bus.BusBchange ? bus.ex_result : bus.busB;

    imm_ext u_imm_ext (
        .op_i  (instr[31:26]),
        .imm_i (instr[15:0]),
        .imm_o (imm)
    );

    assign capture = {{(FIELD_W-PC_W){1'b0}}, pc_lo, imm, opb, opa, instr};

    // Load sitting in EX whose destination is read by the instruction in ID.
    // rt is only a source for R-type; for I-type it is the destination.
    assign ex_op = idex_reg_q[INSTR_LSB+31:INSTR_LSB+26];
    assign ex_rt = idex_reg_q[INSTR_LSB+20:INSTR_LSB+16];
    assign id_op = instr[31:26];
    assign id_rs = instr[25:21];
    assign id_rt = instr[20:16];

    assign hazard = idex_valid_q && is_load_op(ex_op) && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || ((ex_rt == id_rt) && (id_op == OP_RTYPE)));

    // In BUBBLE the EX slot is empty, so no second bubble is ever requested.
    assign bubble_req = (state_q == RUN) && hazard && !bus.flush && !bus.stall;

    always_comb begin
        idex_reg_d   = idex_reg_q;
        idex_valid_d = idex_valid_q;
        state_d      = state_q;
        if (bus.flush) begin
            idex_reg_d   = {{(IDEX_W-DATA_W){1'b0}}, NOP_WORD};
            idex_valid_d = 1'b0;
            state_d      = RUN;
        end else if (bus.stall) begin
            // hold everything
        end else if (bubble_req) begin
            idex_reg_d   = {{(IDEX_W-DATA_W){1'b0}}, NOP_WORD};
            idex_valid_d = 1'b0;
            state_d      = BUBBLE;
        end else begin
            idex_reg_d   = capture;
            idex_valid_d = 1'b1;
            state_d      = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_reg_q   <= '0;
            idex_valid_q <= 1'b0;
            state_q      <= RUN;
        end else begin
            idex_reg_q   <= idex_reg_d;
            idex_valid_q <= idex_valid_d;
            state_q      <= state_d;
        end
    end

    assign bus.idex_reg   = idex_reg_q;
    assign bus.idex_valid = idex_valid_q;
    assign bus.load_stall = bubble_req;

`ifdef IDEX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    assign bubble_cnt_d = (bubble_req && (bubble_cnt_q != 16'hFFFF)) ? bubble_cnt_q + 16'd1
                                                                      : bubble_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= 16'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_idex_stage.sv
// tb/tb_idex_stage.sv - directed self-checking bench for idex_stage
module tb_idex_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    idex_stage_if bus ();

    idex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // instruction words
    localparam logic [31:0] I_ADD_3_1_2  = 32'h00221820; // add $3,$1,$2
    localparam logic [31:0] I_ORI_4      = 32'h34048001; // ori $4,$0,0x8001
    localparam logic [31:0] I_ADDI_4     = 32'h20048001; // addi $4,$0,0x8001
    localparam logic [31:0] I_LW_5       = 32'h8C250000; // lw $5,0($1)
    localparam logic [31:0] I_LBU_5      = 32'h90250000; // lbu $5,0($1)
    localparam logic [31:0] I_ADD_6_5_2  = 32'h00A23020; // add $6,$5,$2
    localparam logic [31:0] I_LW_0       = 32'h8C200000; // lw $0,0($1)
    localparam logic [31:0] I_ADD_6_0_2  = 32'h00023020; // add $6,$0,$2
    localparam logic [31:0] I_LW_9       = 32'h8C290000; // lw $9,0($1)
    localparam logic [31:0] I_ADDI_7_5   = 32'h20A70001; // addi $7,$5,1
    localparam logic [31:0] I_ADD_6_2_5  = 32'h00453020; // add $6,$2,$5
    localparam logic [31:0] I_ADDI_5_2   = 32'h20450001; // addi $5,$2,1

    task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] mk(input logic [31:0] instr, input logic [11:0] pc,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] imm);
        return {20'h00000, pc, imm, b, a, instr};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [11:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] ex,
                         input logic ac, input logic bc);
        bus.ifid_reg   = {pc, instr};
        bus.busA       = a;
        bus.busB       = b;
        bus.ex_result  = ex;
        bus.BusAchange = ac;
        bus.BusBchange = bc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(32'h0, 12'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        check_eq("rst_reg", bus.idex_reg, '0);
        check_eq("rst_valid", bus.idex_valid, 0);
        check_eq("rst_ls", bus.load_stall, 0);
        rst_n = 1'b1;

        // capture with forwarding on A
        drive(I_ADD_3_1_2, 12'h010, 32'd5, 32'd7, 32'd99, 1'b1, 1'b0);
        step();
        check_eq("fwd_opa", bus.idex_reg[63:32], 32'd99);
        check_eq("fwd_opb", bus.idex_reg[95:64], 32'd7);
        check_eq("fwd_valid", bus.idex_valid, 1);
        check_eq("fwd_full", bus.idex_reg, mk(I_ADD_3_1_2, 12'h010, 32'd99, 32'd7, 32'h00001820));

        // immediate extension
        drive(I_ORI_4, 12'h014, 32'd11, 32'd2, 32'd99, 1'b0, 1'b0);
        step();
        check_eq("imm_ori", bus.idex_reg[127:96], 32'h00008001);
        check_eq("nofwd_opa", bus.idex_reg[63:32], 32'd11);
        drive(I_ADDI_4, 12'h018, 32'd11, 32'd2, 32'd99, 1'b0, 1'b1);
        step();
        check_eq("imm_addi", bus.idex_reg[127:96], 32'hFFFF8001);
        check_eq("fwd_opb_only", bus.idex_reg[95:64], 32'd99);
        check_eq("pc_field", bus.idex_reg[159:128], 32'h00000018);

        // load-use bubble on rs
        drive(I_LW_5, 12'h01C, 32'd100, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        drive(I_ADD_6_5_2, 12'h020, 32'd3, 32'd4, 32'd55, 1'b1, 1'b0);
        #1;
        check_eq("lu_ls_on", bus.load_stall, 1);
        step();
        check_eq("lu_valid0", bus.idex_valid, 0);
        check_eq("lu_reg0", bus.idex_reg, '0);
        check_eq("lu_ls_off", bus.load_stall, 0);
        drive(I_ADD_6_5_2, 12'h020, 32'd3, 32'd4, 32'd55, 1'b0, 1'b0);
        step();
        check_eq("lu_capture", bus.idex_reg, mk(I_ADD_6_5_2, 12'h020, 32'd3, 32'd4, 32'h00003020));
        check_eq("lu_valid1", bus.idex_valid, 1);
`ifdef IDEX_BUBBLE_CNT_EN
        check_eq("cnt_1", bus.bubble_cnt, 16'd1);
`endif

        // no hazard: load to $0
        drive(I_LW_0, 12'h024, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        step();
        drive(I_ADD_6_0_2, 12'h028, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        #1;
        check_eq("r0_ls", bus.load_stall, 0);
        step();
        check_eq("r0_instr", bus.idex_reg[31:0], I_ADD_6_0_2);

        // no hazard: different register
        drive(I_LW_9, 12'h02C, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        step();
        drive(I_ADDI_7_5, 12'h030, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        #1;
        check_eq("diff_ls", bus.load_stall, 0);
        step();
        check_eq("diff_instr", bus.idex_reg[31:0], I_ADDI_7_5);

        // hazard through R-type rt, using lbu
        drive(I_LBU_5, 12'h034, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        step();
        drive(I_ADD_6_2_5, 12'h038, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        #1;
        check_eq("rt_ls", bus.load_stall, 1);
        step();
        check_eq("rt_valid0", bus.idex_valid, 0);
        step();
        check_eq("rt_instr", bus.idex_reg[31:0], I_ADD_6_2_5);
`ifdef IDEX_BUBBLE_CNT_EN
        check_eq("cnt_2", bus.bubble_cnt, 16'd2);
`endif

        // I-type rt is a destination: no hazard
        drive(I_LW_5, 12'h03C, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        step();
        drive(I_ADDI_5_2, 12'h040, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        #1;
        check_eq("itype_rt_ls", bus.load_stall, 0);
        step();
        check_eq("itype_rt_valid", bus.idex_valid, 1);

        // flush beats load-use
        drive(I_LW_5, 12'h044, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        step();
        drive(I_ADD_6_5_2, 12'h048, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        bus.flush = 1'b1;
        #1;
        check_eq("flush_ls", bus.load_stall, 0);
        step();
        check_eq("flush_reg", bus.idex_reg, '0);
        check_eq("flush_valid", bus.idex_valid, 0);
        bus.flush = 1'b0;
        #1;
        check_eq("postflush_ls", bus.load_stall, 0);
        step();
        check_eq("postflush_cap", bus.idex_reg, mk(I_ADD_6_5_2, 12'h048, 32'd3, 32'd4, 32'h00003020));
`ifdef IDEX_BUBBLE_CNT_EN
        check_eq("cnt_flush", bus.bubble_cnt, 16'd2);
`endif

        // stall holds
        drive(I_ORI_4, 12'h04C, 32'd8, 32'd9, 32'd0, 1'b0, 1'b0);
        bus.stall = 1'b1;
        step();
        check_eq("stall_hold", bus.idex_reg, mk(I_ADD_6_5_2, 12'h048, 32'd3, 32'd4, 32'h00003020));
        check_eq("stall_valid", bus.idex_valid, 1);
        bus.stall = 1'b0;
        step();
        check_eq("unstall_cap", bus.idex_reg, mk(I_ORI_4, 12'h04C, 32'd8, 32'd9, 32'h00008001));

        // stall beats load-use, bubble follows once released
        drive(I_LW_5, 12'h050, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        step();
        drive(I_ADD_6_5_2, 12'h054, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        bus.stall = 1'b1;
        #1;
        check_eq("stall_ls", bus.load_stall, 0);
        step();
        check_eq("stall_lw_hold", bus.idex_reg[31:0], I_LW_5);
        bus.stall = 1'b0;
        #1;
        check_eq("unstall_ls", bus.load_stall, 1);
        step();
        check_eq("unstall_bubble", bus.idex_valid, 0);
        step();
        check_eq("unstall_instr", bus.idex_reg[31:0], I_ADD_6_5_2);
`ifdef IDEX_BUBBLE_CNT_EN
        check_eq("cnt_3", bus.bubble_cnt, 16'd3);
`endif

        // asynchronous reset mid-cycle on a valid register
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_reg", bus.idex_reg, '0);
        check_eq("arst_valid", bus.idex_valid, 0);
`ifdef IDEX_BUBBLE_CNT_EN
        check_eq("arst_cnt", bus.bubble_cnt, 16'd0);
`endif
        step();
        rst_n = 1'b1;

        // asynchronous reset mid-bubble
        drive(I_LW_5, 12'h058, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        step();
        drive(I_ADD_6_5_2, 12'h05C, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        #1;
        check_eq("mb_ls_on", bus.load_stall, 1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mb_ls", bus.load_stall, 0);
        check_eq("mb_valid", bus.idex_valid, 0);
        step();
        rst_n = 1'b1;
        drive(I_LW_5, 12'h060, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        step();
        check_eq("mb_recap", bus.idex_reg[31:0], I_LW_5);
        drive(I_ADD_6_5_2, 12'h064, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
        #1;
        check_eq("mb_run_ls", bus.load_stall, 1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
